// File: rtl/rom_req_ctrl.sv
// Request/response front end for rom_tech: forwards addresses combinationally,
// captures read data one cycle later into a 2-entry in-order response FIFO.
module rom_req_ctrl #(
   parameter  int abits       = 12,
   parameter  int log2_dbytes = 3,
   localparam int dbits       = 8 * (2 ** log2_dbytes)
) (
   input  logic             i_clk,
   input  logic             i_nrst,
   input  logic             i_req_valid,
   output logic             o_req_ready,
   input  logic [abits-1:0] i_req_addr,
   input  logic             i_req_write,
   output logic [abits-1:0] o_rom_addr,
   input  logic [dbits-1:0] i_rom_data,
   output logic             o_resp_valid,
   input  logic             i_resp_ready,
   output logic [dbits-1:0] o_resp_data,
   output logic             o_resp_err,
   output logic [15:0]      o_err_cnt
);

   typedef struct packed {
      logic             err;
      logic [dbits-1:0] data;
   } entry_t;

   entry_t     mem [2];
   entry_t     head;
   entry_t     push_entry;
   logic       wr_ptr, rd_ptr;
   logic [1:0] cnt;
   logic       inflight, inflight_wr;
   logic [15:0] err_cnt;
   logic       push, pop, accept;
   logic [2:0] occ;

   // Word selection happens inside rom_tech, so the full byte address passes through.
   assign o_rom_addr = i_req_addr;

   assign head         = mem[rd_ptr];
   assign o_resp_valid = (cnt != 2'd0);
   assign pop          = o_resp_valid & i_resp_ready;
   assign push         = inflight;

   // Occupancy after this edge if nothing new is accepted; keeps the FIFO from overflowing.
   assign occ         = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
   assign o_req_ready = i_nrst & (occ < 3'd2);
   assign accept      = i_req_valid & o_req_ready;

   always_comb begin
      push_entry = '0;
      if (inflight_wr) begin
         push_entry.err = 1'b1;
      end else begin
         push_entry.data = i_rom_data;
      end
   end

   // Head is gated so a reset (or empty) FIFO presents zeros, never stale storage.
   assign o_resp_data = o_resp_valid ? head.data : '0;
   assign o_resp_err  = o_resp_valid & head.err;
   assign o_err_cnt   = err_cnt;

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         inflight    <= 1'b0;
         inflight_wr <= 1'b0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         cnt         <= 2'd0;
         err_cnt     <= 16'd0;
      end else begin
         inflight    <= accept;
         inflight_wr <= accept & i_req_write;
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         cnt <= cnt + {1'b0, push} - {1'b0, pop};
         if (pop && head.err && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
         end
      end
   end

   // NOTE: storage is deliberately not reset; cnt and the pointers define what is valid.
   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= push_entry;
   end

endmodule
